// File: rtl/bcd_div_pkg.sv
// bcd_div_pkg: shared FSM state type and BCD digit constants for the
// digit-serial BCD long divider.
package bcd_div_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when a nibble is a legal decimal digit.
  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_sub_cmp_ndigits.sv
// bcd_sub_cmp_ndigits: combinational N-digit BCD subtractor, diff = a - b.
// borrow = 0 means a >= b, so one instance serves as both the comparator
// and the subtractor of the long divider.
module bcd_sub_cmp_ndigits
  import bcd_div_pkg::*;
#(
  parameter int NDIGITS = 5
) (
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  output logic [DIGIT_W*NDIGITS-1:0] diff,
  output logic                       borrow
);

  logic                bin;
  logic [DIGIT_W:0]    digit_diff;

  // Ripple the borrow from the least significant digit upward; a negative
  // digit difference is corrected by adding ten.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    bin        = 1'b0;
    diff       = '0;
    digit_diff = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      digit_diff = {1'b0, a[DIGIT_W*i +: DIGIT_W]}
                 - {1'b0, b[DIGIT_W*i +: DIGIT_W]}
                 - {{DIGIT_W{1'b0}}, bin};
      if (digit_diff[DIGIT_W]) begin
        diff[DIGIT_W*i +: DIGIT_W] = digit_diff[DIGIT_W-1:0] + 4'd10;
        bin = 1'b1;
      end else begin
        diff[DIGIT_W*i +: DIGIT_W] = digit_diff[DIGIT_W-1:0];
        bin = 1'b0;
      end
    end
    borrow = bin;
  end

endmodule

// File: rtl/bcd_long_divider.sv
// bcd_long_divider: digit-serial restoring BCD long division.
// Each dividend digit costs one SHIFT cycle, one SUB cycle per unit of the
// quotient digit, and one final SUB cycle that finds remainder < divisor.
// A zero divisor finishes one edge after acceptance with err set.
// Optional macro BCD_DIV_INPUT_CHECK_EN: non-BCD operand nibbles also
// finish early with err set and zero results.
module bcd_long_divider
  import bcd_div_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] dividend,
  input  logic [DIGIT_W*NDIGITS-1:0] divisor,
  output logic [DIGIT_W*NDIGITS-1:0] quotient,
  output logic [DIGIT_W*NDIGITS-1:0] remainder,
  output logic                       busy,
  output logic                       end_division,
  output logic                       err
);

  localparam int W  = DIGIT_W * NDIGITS;
  localparam int RW = DIGIT_W * (NDIGITS + 1);
  localparam int CW = $clog2(NDIGITS + 1);

  state_t          state, state_next;
  logic [W-1:0]    dvd_q, dvs_q, quo_q;
  logic [RW-1:0]   rem_q, diff;
  logic [CW-1:0]   left_q;
  logic            err_q;
  logic            borrow, can_sub, non_bcd, bad_ops;
  logic [DIGIT_W-1:0] next_digit;

  bcd_sub_cmp_ndigits #(.NDIGITS(NDIGITS + 1)) u_sub (
    .a      (rem_q),
    .b      ({{DIGIT_W{1'b0}}, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Stop subtracting once the digit reaches nine so garbage inputs still
  // terminate.
  assign can_sub = !borrow && (quo_q[DIGIT_W-1:0] != BCD_NINE);

`ifdef BCD_DIV_INPUT_CHECK_EN
  // Flag any latched operand nibble that is not a decimal digit.
  always_comb begin
    non_bcd = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!is_bcd_digit(dvd_q[DIGIT_W*i +: DIGIT_W]) ||
          !is_bcd_digit(dvs_q[DIGIT_W*i +: DIGIT_W]))
        non_bcd = 1'b1;
    end
  end
`else
  assign non_bcd = 1'b0;
`endif

  assign bad_ops = (dvs_q == '0) || non_bcd;

  // Select the dividend digit to bring down; left_q counts digits remaining.
  always_comb begin
    next_digit = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (left_q == CW'(i + 1)) next_digit = dvd_q[DIGIT_W*i +: DIGIT_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   state_next = bad_ops ? DONE : SUB;
      SUB:     if (!can_sub) state_next = (left_q == '0) ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, digit shift-in, subtract and quotient count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      left_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            rem_q  <= '0;
            quo_q  <= '0;
            left_q <= CW'(NDIGITS);
            err_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bad_ops) begin
            err_q <= 1'b1;
            rem_q <= non_bcd ? '0 : {{DIGIT_W{1'b0}}, dvd_q};
          end else begin
            rem_q  <= {rem_q[RW-DIGIT_W-1:0], next_digit};
            quo_q  <= {quo_q[W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
            left_q <= left_q - CW'(1);
          end
        end
        SUB: begin
          if (can_sub) begin
            rem_q                <= diff;
            quo_q[DIGIT_W-1:0]   <= quo_q[DIGIT_W-1:0] + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy         = 1'b0;
    end_division = 1'b0;
    case (state)
      SHIFT, SUB: busy = 1'b1;
      DONE:       end_division = 1'b1;
      default:    ;
    endcase
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[W-1:0];
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_long_divider.sv
// tb_bcd_long_divider: directed self-checking bench for bcd_long_divider
// (NDIGITS=4). Expected results come from an integer reference model and
// are queued when a division is launched, then popped at completion.
// Latency is counted in rising edges after the accepting edge.
module tb_bcd_long_divider;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    bit           data_known;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, end_division, err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_long_divider #(.NDIGITS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .end_division (end_division),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int acc = 0;
    for (int i = N - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   qi, s;
    e.data_known = 1'b1;
    if (b == '0) begin
      e.q = '0; e.r = a; e.e = 1'b1; e.lat = 1;
    end else begin
      qi  = bcd_to_int(a) / bcd_to_int(b);
      e.q = int_to_bcd(qi);
      e.r = int_to_bcd(bcd_to_int(a) % bcd_to_int(b));
      e.e = 1'b0;
      s   = 0;
      for (int i = 0; i < N; i++) s += int'(e.q[4*i +: 4]);
      e.lat = 2 * N + s;
    end
    return e;
  endfunction

  // Launch one division, wait (bounded) for end_division, compare against
  // the scoreboard. With poke set, a second start carrying other operands is
  // pulsed so that it is sampled at edge 3 after acceptance.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit poke);
    exp_t want;
    int   lat;
    bit   done;
    sb.push_back(e);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 11 * N + 1) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (poke && lat == 2) begin
        start = 1'b1; dividend = 16'h9999; divisor = 16'h0001;
      end
      if (end_division) done = 1'b1;
    end
    start = 1'b0;
    want  = sb.pop_front();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " err"}, 32'(err), 32'(want.e));
    if (want.data_known) begin
      check({tag, " quotient"}, 32'(quotient), 32'(want.q));
      check({tag, " remainder"}, 32'(remainder), 32'(want.r));
      check({tag, " latency"}, 32'(lat), 32'(want.lat));
    end else begin
      check({tag, " latency_bound"}, 32'(lat <= 11 * N + 1), 32'd1);
    end
    @(negedge clk);
    check({tag, " pulse_one_cycle"}, 32'(end_division), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    if (want.data_known) begin
      repeat (2) @(negedge clk);
      check({tag, " quotient_held"}, 32'(quotient), 32'(want.q));
      check({tag, " remainder_held"}, 32'(remainder), 32'(want.r));
    end
  endtask

  initial begin
    exp_t e;
    bit   saw_end;

    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset end_division", 32'(end_division), 32'd0);
    check("reset err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("1234/0011", 16'h1234, 16'h0011, model(16'h1234, 16'h0011), 1'b0);
    run_op("9999/0001", 16'h9999, 16'h0001, model(16'h9999, 16'h0001), 1'b0);
    run_op("0005/0007", 16'h0005, 16'h0007, model(16'h0005, 16'h0007), 1'b1);
    run_op("4321/0000", 16'h4321, 16'h0000, model(16'h4321, 16'h0000), 1'b0);
    run_op("9999/9999", 16'h9999, 16'h9999, model(16'h9999, 16'h9999), 1'b0);
    run_op("8765/0123", 16'h8765, 16'h0123, model(16'h8765, 16'h0123), 1'b0);
    run_op("0000/0005", 16'h0000, 16'h0005, model(16'h0000, 16'h0005), 1'b0);

    // Reset in the middle of a SUB phase abandons the division.
    @(negedge clk);
    dividend = 16'h1234; divisor = 16'h0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midop busy_before_reset", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midop_reset quotient", 32'(quotient), 32'd0);
    check("midop_reset remainder", 32'(remainder), 32'd0);
    check("midop_reset busy", 32'(busy), 32'd0);
    check("midop_reset err", 32'(err), 32'd0);
    saw_end = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (end_division) saw_end = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (end_division || busy) saw_end = 1'b1;
    end
    check("midop_reset no_completion", 32'(saw_end), 32'd0);

    run_op("0100/0010", 16'h0100, 16'h0010, model(16'h0100, 16'h0010), 1'b0);

`ifdef BCD_DIV_INPUT_CHECK_EN
    e.q = '0; e.r = '0; e.e = 1'b1; e.lat = 1; e.data_known = 1'b1;
`else
    e.q = '0; e.r = '0; e.e = 1'b0; e.lat = 0; e.data_known = 1'b0;
`endif
    run_op("12A4/0003", 16'h12A4, 16'h0003, e, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
